// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: each channel emits a one-cycle clock-enable pulse
// and a 50%-duty toggle at a programmable divisor, in periodic or one-shot mode.
module multi_tick_gen #(
   parameter int          CHANNELS    = 4,
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 25000000,
   localparam int         CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sync_clr,
   input  logic [CHANNELS-1:0] en,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [CNT_W-1:0]    wr_div,
   input  logic                wr_mode,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0]    cnt      [CHANNELS];
   logic [CNT_W-1:0]    div      [CHANNELS];
   logic [CNT_W-1:0]    last_cnt [CHANNELS];
   logic [1:0]          state    [CHANNELS];
   logic [CHANNELS-1:0] mode;
   logic [CHANNELS-1:0] wr_sel;

   // A stored divisor of zero behaves as one, so the terminal count is div-1 clamped at 0.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         last_cnt[i] = (div[i] == '0) ? '0 : div[i] - CNT_W'(1);
      end
   end

   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_sel[i] = wr_en && (int'(wr_ch) < CHANNELS) && (int'(wr_ch) == i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i]     <= '0;
            div[i]     <= RESET_DIV;
            state[i]   <= ST_IDLE;
            mode[i]    <= 1'b0;
            tick[i]    <= 1'b0;
            clk_out[i] <= 1'b0;
            busy[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync_clr) begin
               cnt[i]     <= '0;
               state[i]   <= ST_IDLE;
               tick[i]    <= 1'b0;
               clk_out[i] <= 1'b0;
               busy[i]    <= 1'b0;
            end else if (wr_sel[i]) begin
               // Reconfiguration restarts the period from zero and swallows any pending tick.
               div[i]   <= wr_div;
               mode[i]  <= wr_mode;
               cnt[i]   <= '0;
               state[i] <= ST_IDLE;
               tick[i]  <= 1'b0;
               busy[i]  <= 1'b0;
            end else begin
               case (state[i])
                  ST_IDLE: begin
                     tick[i] <= 1'b0;
                     if (en[i]) begin
                        state[i] <= ST_RUN;
                        busy[i]  <= 1'b1;
                     end
                  end
                  ST_RUN: begin
                     if (!en[i]) begin
                        state[i] <= ST_IDLE;
                        busy[i]  <= 1'b0;
                        tick[i]  <= 1'b0;
                     end else if (cnt[i] >= last_cnt[i]) begin
                        cnt[i]     <= '0;
                        tick[i]    <= 1'b1;
                        clk_out[i] <= ~clk_out[i];
                        if (mode[i]) begin
                           state[i] <= ST_DONE;
                           busy[i]  <= 1'b0;
                        end
                     end else begin
                        cnt[i]  <= cnt[i] + CNT_W'(1);
                        tick[i] <= 1'b0;
                     end
                  end
                  ST_DONE: begin
                     tick[i] <= 1'b0;
                     if (!en[i]) begin
                        state[i] <= ST_IDLE;
                        cnt[i]   <= '0;
                     end
                  end
                  default: begin
                     state[i] <= ST_IDLE;
                     busy[i]  <= 1'b0;
                     tick[i]  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Parametrised, multi-channel successor to the single fixed-rate clock divider.
- Produces, per channel, a one-cycle clock-enable pulse (tick) and a 50%-duty toggle output (clk_out) from the single system clock.
- Each channel has a runtime-programmable divisor, a periodic or one-shot mode, and a run enable.
- Feeds game timing (bird physics step, pipe scroll, score blink, animation) without creating derived clock domains.

Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- CNT_W, 32: counter and divisor width.
- DEFAULT_DIV, 25000000: reset divisor for every channel (tick = 2 Hz, clk_out = 1 Hz at 50 MHz).
- CH_W, $clog2(CHANNELS) (min 1): local parameter, channel-select width.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous clear of all channels.
- en  in  CHANNELS  per-channel run enable, level sensitive.
- wr_en  in  1  configuration write strobe, one cycle.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_div  in  CNT_W  new divisor (period of tick in clk cycles).
- wr_mode  in  1  new mode: 0 periodic, 1 one-shot.
- tick  out  CHANNELS  registered one-cycle pulse per terminal count.
- clk_out  out  CHANNELS  registered toggle, flips on every tick.
- busy  out  CHANNELS  high while channel is in RUN.

Behaviour:
- Reset (rst_n=0, async): cnt=0, div=DEFAULT_DIV, mode=periodic, state=IDLE, tick=0, clk_out=0, busy=0 for all channels.
- Divisor handling:
  - Effective divisor div_eff = (div==0) ? 1 : div.
  - div_eff=1 gives a tick every cycle and a clk_out toggle every cycle.
  - The written wr_div is stored as given; the clamp is applied at compare.
- Per-channel FSM, states IDLE, RUN, DONE:
  - IDLE: cnt holds. en=1 sampled -> RUN. cnt does not advance on the entry edge.
  - RUN, counting: if cnt >= div_eff-1, then next edge cnt<=0, tick<=1, clk_out<=~clk_out. Otherwise cnt<=cnt+1, tick<=0.
  - RUN, periodic mode: en=0 sampled -> IDLE. cnt and clk_out hold (pause/resume, no phase loss).
  - RUN, one-shot mode: the terminal-count edge issues the tick and goes to DONE. en=0 in RUN -> IDLE with cnt holding.
  - DONE: no counting, tick=0. en=0 sampled -> IDLE with cnt<=0. en held high keeps DONE (re-arm requires en low then high).
- Latency: first tick is high in the cycle after the edge that is div_eff edges after the RUN-entry edge. Subsequent ticks repeat every div_eff cycles; clk_out period is 2*div_eff.
- busy = (state==RUN), registered with state.
- Config write (wr_en=1, wr_ch<CHANNELS), next edge on the addressed channel:
  - div<=wr_div, mode<=wr_mode, cnt<=0, state<=IDLE, tick<=0; clk_out holds.
  - If en is still 1, the channel re-enters RUN on the following edge.
  - wr_ch>=CHANNELS: write ignored, no state change.
- Priority per channel, highest first: rst_n, sync_clr, write, en/counting.
  - A write coinciding with a terminal count suppresses that tick.
  - sync_clr: all cnt=0, tick=0, clk_out=0, state=IDLE; div and mode are preserved; any same-cycle write is ignored.
- Channels are fully independent; a write to one channel never disturbs another.
- All outputs are driven directly from flops. No combinational path exists from inputs to outputs.
- Arithmetic: unsigned CNT_W-bit. cnt never exceeds div_eff-1 in steady state; the >= compare recovers safely if div decreases.

Test Plan:
- Reset, then write ch0 div=4 mode=0, en[0]=1 -> tick[0] high one cycle every 4 cycles; clk_out[0] period 8; busy[0]=1; other channels stay idle with outputs 0.
- ch1 div=5 one-shot, en[1]=1 held for 20 cycles -> exactly one tick[1], 5 cycles after RUN entry, then busy[1]=0. en low 1 cycle, then high -> second single tick.
- ch0 running div=4, drop en[0] at cnt=2 for 3 cycles, then raise it -> next tick 2 counting cycles after resume; clk_out[0] unchanged during pause.
- div=0 and div=1 on ch2 -> tick[2] constant high while RUN; clk_out[2] toggles every cycle.
- Write ch0 on its terminal-count cycle -> no tick that cycle, cnt restarts from 0 with the new div. Write with wr_ch=7 (CHANNELS=4) -> no change anywhere.
- Assert sync_clr together with wr_en, then assert rst_n=0 asynchronously mid-count -> sync_clr: all outputs 0 next edge and old div is kept. rst_n: outputs 0 immediately with div=DEFAULT_DIV.
